// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types for the Wishbone command master
// Contents: default widths, response status codes, command record, FSM states.
package wb_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

    typedef enum logic [1:0] {
        WB_OK      = 2'b00,
        WB_ERR     = 2'b01,
        WB_TIMEOUT = 2'b10
    } wb_status_e;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
        logic [WB_SEL_W-1:0]  sel;
    } wb_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUS  = 2'b01,
        S_RSP  = 2'b10
    } wb_state_e;

    // Width of one packed command entry: we + adr + dat + sel.
    function automatic int wb_cmd_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// rtl/wb_cmd_fifo.sv - synchronous command FIFO
// Ports: clk, rst (sync, active-low); push/push_data write side;
//        pop/pop_data read side (show-ahead); full, empty, count status.
module wb_cmd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      wr_ptr_vis;
    logic [AW:0]      rd_ptr;

    // A written entry becomes visible to the read side one cycle after the
    // push; this registered boundary gives the two-cycle accept-to-bus
    // latency while leaving back-to-back draining of queued entries intact.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            wr_ptr_vis <= '0;
            rd_ptr     <= '0;
        end else begin
            wr_ptr_vis <= wr_ptr;
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr_vis == rd_ptr);
    assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic-cycle command master
// Ports: clk, rst (sync, active-low); cmd_* command valid/ready input;
//        rsp_* response valid/ready output; wb_* Wishbone master bus;
//        irq_pend sticky slave interrupt flag, cleared by irq_clr.
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int SEL_W      = DATA_W / 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_adr,
    input  logic [DATA_W-1:0] cmd_dat,
    input  logic [SEL_W-1:0]  cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_dat,
    output logic [1:0]        rsp_status,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_int_i,
    output logic              irq_pend,
    input  logic              irq_clr
);

    localparam int CMD_W   = wb_cmd_width(ADDR_W, DATA_W);
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [FCNT_W-1:0] FIFO_MAX = FCNT_W'(FIFO_DEPTH);

    wb_state_e         state_q;
    wb_state_e         state_d;
    wb_status_e        done_status;
    logic              bus_done;
    logic              fifo_pop;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic [CMD_W-1:0]  fifo_rdata;
    logic [CNT_W-1:0]  wait_cnt;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    wb_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({cmd_we, cmd_adr, cmd_dat, cmd_sel}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Occupancy can never exceed the FIFO depth.
    assert property (@(posedge clk) disable iff (!rst) fifo_count <= FIFO_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // err has priority over ack; the watchdog only fires with neither present.
    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        bus_done    = 1'b0;
        done_status = WB_OK;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = S_BUS;
                end
            end
            S_BUS: begin
                if (wb_stb_o) begin
                    if (wb_err_i) begin
                        bus_done    = 1'b1;
                        done_status = WB_ERR;
                    end else if (wb_ack_i) begin
                        bus_done    = 1'b1;
                        done_status = WB_OK;
                    end else if ((TIMEOUT > 0) && (wait_cnt == CNT_LAST)) begin
                        bus_done    = 1'b1;
                        done_status = WB_TIMEOUT;
                    end
                end
                if (bus_done) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_cyc_o   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
            rsp_status <= 2'b00;
            wait_cnt   <= '0;
        end else begin
            if (fifo_pop) begin
                wb_we_o  <= fifo_rdata[CMD_W-1];
                wb_adr_o <= fifo_rdata[CMD_W-2 -: ADDR_W];
                wb_dat_o <= fifo_rdata[SEL_W +: DATA_W];
                wb_sel_o <= fifo_rdata[SEL_W-1:0];
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wait_cnt <= '0;
            end else if (bus_done) begin
                // adr/dat/sel deliberately hold their last values.
                wb_cyc_o   <= 1'b0;
                wb_stb_o   <= 1'b0;
                wb_we_o    <= 1'b0;
                rsp_valid  <= 1'b1;
                rsp_status <= done_status;
                rsp_dat    <= ((done_status == WB_OK) && !wb_we_o) ? wb_dat_i : '0;
            end else if ((state_q == S_BUS) && (wait_cnt != CNT_SAT)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if ((state_q == S_RSP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_pend <= 1'b0;
        end else if (wb_int_i) begin
            irq_pend <= 1'b1;
        end else if (irq_clr) begin
            irq_pend <= 1'b0;
        end
    end

endmodule
